xgmii_32b64b_retransmit: RTL and testbench



---
 rtl/xgmii_retx_pkg.sv | 24 ++
 rtl/xgmii_retx_fifo.sv | 59 +++++
 rtl/xgmii_32b64b_retransmit.sv | 95 +++++++++
 tb/tb_xgmii_32b64b_retransmit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_retx_pkg.sv
// Shared XGMII code points, the 64-bit word type and gearbox phase
// encoding for the 32b->64b retransmit block.
package xgmii_retx_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  localparam logic [63:0] IDLE_WORD64 = {8{XGMII_IDLE}};

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } xgmii64_t;

  localparam xgmii64_t IDLE_XGMII = '{ctrl: 8'hFF, data: IDLE_WORD64};

  typedef enum logic {
    PHASE_LOW  = 1'b0,
    PHASE_HIGH = 1'b1
  } gear_phase_t;

endpackage

// File: rtl/xgmii_retx_fifo.sv
// Synchronous show-ahead FIFO of 64-bit XGMII words; the head entry is
// presented combinationally whenever the FIFO is not empty.
module xgmii_retx_fifo
  import xgmii_retx_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  xgmii64_t      wr_word,
  input  logic          rd_en,
  output xgmii64_t      rd_word,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  xgmii64_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic            do_wr;
  logic            do_rd;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  assign rd_word = mem[rd_ptr];

  // A write into a full FIFO is only allowed when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xgmii_32b64b_retransmit.sv
// 32-bit to 64-bit XGMII gearbox feeding a show-ahead FIFO with sticky overflow.
// Define XGMII_RETX_IDLE_FILL_EN to present all-Idle words while the FIFO is empty.
module xgmii_32b64b_retransmit
  import xgmii_retx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                tx_data,
  input  logic [3:0]                 tx_ctrl,
  input  logic                       tx_valid,
  output logic [63:0]                rx_data,
  output logic [7:0]                 rx_ctrl,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  gear_phase_t phase;
  logic [31:0] low_data;
  logic [3:0]  low_ctrl;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  xgmii64_t    push_word;
  xgmii64_t    head_word;
  xgmii64_t    out_word;

  assign push      = tx_valid && (phase == PHASE_HIGH);
  assign pop       = rx_valid && rx_ready;
  assign push_word = '{ctrl: {tx_ctrl, low_ctrl}, data: {tx_data, low_data}};

  // The low half waits here until its partner arrives; idle cycles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PHASE_LOW;
      low_data <= '0;
      low_ctrl <= '0;
    end else if (tx_valid) begin
      if (phase == PHASE_LOW) begin
        low_data <= tx_data;
        low_ctrl <= tx_ctrl;
        phase    <= PHASE_HIGH;
      end else begin
        phase    <= PHASE_LOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  xgmii_retx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_word (push_word),
    .rd_en   (pop),
    .rd_word (head_word),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

`ifdef XGMII_RETX_IDLE_FILL_EN
  assign rx_valid = 1'b1;
  assign out_word = fifo_empty ? IDLE_XGMII : head_word;
`else
  xgmii64_t last_word;

  // Remembers the most recently delivered word so the bus holds still when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word <= IDLE_XGMII;
    end else if (pop) begin
      last_word <= head_word;
    end
  end

  assign rx_valid = !fifo_empty;
  assign out_word = fifo_empty ? last_word : head_word;
`endif

  assign rx_data = out_word.data;
  assign rx_ctrl = out_word.ctrl;

endmodule

// File: tb/tb_xgmii_32b64b_retransmit.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed literal checks of packing, overflow, reset and idle behaviour.
module tb_xgmii_32b64b_retransmit;
  import xgmii_retx_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   tx_data;
  logic [3:0]    tx_ctrl;
  logic          tx_valid;
  logic [63:0]   rx_data;
  logic [7:0]    rx_ctrl;
  logic          rx_valid;
  logic          rx_ready;
  logic [LW-1:0] level;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  xgmii_32b64b_retransmit #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_ctrl  (tx_ctrl),
    .tx_valid (tx_valid),
    .rx_data  (rx_data),
    .rx_ctrl  (rx_ctrl),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h, required %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: words are queued whole, the oldest one is what the consumer sees.
  xgmii64_t    mq[$];
  xgmii64_t    m_last;
  xgmii64_t    m_word;
  logic        m_have_low;
  logic [31:0] m_low_d;
  logic [3:0]  m_low_c;
  logic        m_ovf;
  logic        m_pop;
  logic        m_push;
  int          m_size;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last     = IDLE_XGMII;
      m_have_low = 1'b0;
      m_low_d    = '0;
      m_low_c    = '0;
      m_ovf      = 1'b0;
    end else begin
      m_size = mq.size();
      m_pop  = rx_ready && (m_size > 0);
      m_push = 1'b0;
      if (tx_valid) begin
        if (m_have_low) begin
          m_push = 1'b1;
          m_word = '{ctrl: {tx_ctrl, m_low_c}, data: {tx_data, m_low_d}};
        end else begin
          m_low_d = tx_data;
          m_low_c = tx_ctrl;
        end
        m_have_low = !m_have_low;
      end
      if (m_pop) begin
        m_last = mq[0];
        void'(mq.pop_front());
      end
      if (m_push) begin
        if (m_size < DEPTH || m_pop) mq.push_back(m_word);
        else m_ovf = 1'b1;
      end
    end
  end

  xgmii64_t e_word;
  logic     e_valid;

  always @(negedge clk) begin
    if (rst_n) begin
`ifdef XGMII_RETX_IDLE_FILL_EN
      e_valid = 1'b1;
      e_word  = (mq.size() > 0) ? mq[0] : IDLE_XGMII;
`else
      e_valid = (mq.size() > 0);
      e_word  = (mq.size() > 0) ? mq[0] : m_last;
`endif
      checkOutput("model rx_valid", 64'(rx_valid), 64'(e_valid));
      checkOutput("model rx_data", rx_data, e_word.data);
      checkOutput("model rx_ctrl", 64'(rx_ctrl), 64'(e_word.ctrl));
      checkOutput("model level", 64'(level), 64'(mq.size()));
      checkOutput("model overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  function automatic logic [8:0] randLane();
    logic [7:0] codes [4];
    codes[0] = XGMII_IDLE;
    codes[1] = XGMII_START;
    codes[2] = XGMII_TERM;
    codes[3] = XGMII_ERROR;
    if ($urandom_range(0, 3) == 0) return {1'b1, codes[$urandom_range(0, 3)]};
    return {1'b0, 8'($urandom)};
  endfunction

  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] c);
    tx_data  = d;
    tx_ctrl  = c;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic applyRandomWord();
    logic [8:0]  ln;
    logic [31:0] d;
    logic [3:0]  c;
    for (int i = 0; i < 4; i++) begin
      ln = randLane();
      d[i*8 +: 8] = ln[7:0];
      c[i]        = ln[8];
    end
    applyStimulus(d, c);
  endtask

  task automatic idleCycle();
    tx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_ctrl  = '0;
    rx_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset rx_data", rx_data, 64'h0707_0707_0707_0707);
    checkOutput("reset rx_ctrl", 64'(rx_ctrl), 64'hFF);
    checkOutput("reset level", 64'(level), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    idleCycle();
`ifdef XGMII_RETX_IDLE_FILL_EN
    checkOutput("idle fill rx_valid", 64'(rx_valid), 64'd1);
`else
    checkOutput("empty rx_valid", 64'(rx_valid), 64'd0);
`endif

    rx_ready = 1'b1;
    applyStimulus(32'h0707_07FB, 4'h1);
    applyStimulus(32'h5555_5555, 4'h0);
    checkOutput("start lane0 data", rx_data, 64'h5555_5555_0707_07FB);
    checkOutput("start lane0 ctrl", 64'(rx_ctrl), 64'h01);
    checkOutput("start lane0 valid", 64'(rx_valid), 64'd1);

    applyStimulus(32'h0707_0707, 4'hF);
    applyStimulus(32'h5555_55FB, 4'h1);
    checkOutput("start lane4 data", rx_data, 64'h5555_55FB_0707_0707);
    checkOutput("start lane4 ctrl", 64'(rx_ctrl), 64'h1F);
    idleCycle();
`ifdef XGMII_RETX_IDLE_FILL_EN
    checkOutput("idle fill valid", 64'(rx_valid), 64'd1);
    checkOutput("idle fill data", rx_data, 64'h0707_0707_0707_0707);
    checkOutput("idle fill ctrl", 64'(rx_ctrl), 64'hFF);
`else
    checkOutput("drained valid", 64'(rx_valid), 64'd0);
    checkOutput("drained hold data", rx_data, 64'h5555_55FB_0707_0707);
`endif

    for (int i = 0; i < 8; i++) begin
      applyRandomWord();
      idleCycle();
    end

    rx_ready = 1'b0;
    repeat (32) applyRandomWord();
    checkOutput("full level", 64'(level), 64'd16);
    checkOutput("full no overflow", 64'(overflow), 64'd0);
    repeat (2) applyRandomWord();
    checkOutput("overflow set", 64'(overflow), 64'd1);
    checkOutput("overflow level", 64'(level), 64'd16);
    rx_ready = 1'b1;
    repeat (20) idleCycle();
    checkOutput("drain level", 64'(level), 64'd0);
    checkOutput("overflow sticky", 64'(overflow), 64'd1);

    repeat (3) applyRandomWord();
    rst_n = 1'b0;
    idleCycle();
    rst_n = 1'b1;
    checkOutput("post reset level", 64'(level), 64'd0);
    checkOutput("post reset overflow", 64'(overflow), 64'd0);
    applyStimulus(32'hA1B2_C3D4, 4'h2);
    applyStimulus(32'h1122_33FD, 4'h1);
    checkOutput("fresh pair data", rx_data, 64'h1122_33FD_A1B2_C3D4);
    checkOutput("fresh pair ctrl", 64'(rx_ctrl), 64'h12);

    for (int i = 0; i < 3000; i++) begin
      rx_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) != 0) applyRandomWord();
      else idleCycle();
    end
    rx_ready = 1'b1;
    repeat (40) idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
